// File: rtl/rns_32_31_21_5_pkg.sv
// Shared constants, result type and modular folding helpers for the 32/31/21/5 RNS converter.
package rns_32_31_21_5_pkg;

  localparam int unsigned MOD_0    = 32;
  localparam int unsigned MOD_1    = 31;
  localparam int unsigned MOD_2    = 21;
  localparam int unsigned MOD_3    = 5;
  localparam int unsigned MOD_1_K  = 5;
  localparam int unsigned DYN_SIZE = 17;
  localparam int unsigned MAX_MOD  = 5;

  localparam int unsigned N_W   = 18;
  localparam int unsigned RES_W = 5;

  localparam int unsigned LUT_31_SIZE = 10;
  localparam int unsigned LUT_21_SIZE = 230;
  localparam int unsigned LUT_5_SIZE  = 42;

  localparam int unsigned LUT_31_W = 5;
  localparam int unsigned LUT_21_W = 5;
  localparam int unsigned LUT_5_W  = 3;

  localparam int unsigned LUT_31_N = LUT_31_SIZE / LUT_31_W;
  localparam int unsigned LUT_21_N = LUT_21_SIZE / LUT_21_W;
  localparam int unsigned LUT_5_N  = LUT_5_SIZE / LUT_5_W;

  typedef struct packed {
    logic [RES_W-1:0] x0;
    logic [RES_W-1:0] x1;
    logic [RES_W-1:0] x2;
    logic [RES_W-1:0] x3;
  } rns_res_t;

  // 2^5 == 1 (mod 31): summing 5-bit chunks preserves the residue.
  function automatic logic [4:0] fold_mod31(input logic [19:0] v);
    logic [6:0] s1;
    logic [5:0] s2;
    logic [4:0] s3;
    s1 = 7'(v[4:0]) + 7'(v[9:5]) + 7'(v[14:10]) + 7'(v[19:15]);
    s2 = 6'(s1[4:0]) + 6'(s1[6:5]);
    s3 = s2[4:0] + 5'(s2[5]);
    return (s3 == 5'd31) ? '0 : s3;
  endfunction

  // 2^4 == 1 (mod 5): fold nibbles, then at most two conditional subtractions.
  function automatic logic [2:0] fold_mod5(input logic [6:0] v);
    logic [4:0] t;
    logic [4:0] u;
    t = 5'(v[3:0]) + 5'(v[6:4]);
    u = 5'(t[3:0]) + 5'(t[4]);
    if (u >= 5'd10) u = u - 5'd10;
    if (u >= 5'd5)  u = u - 5'd5;
    return u[2:0];
  endfunction

endpackage

// File: rtl/rns_lut_sel.sv
// Selects entry k of width W from an ascending-index LUT vector (lowest bit index = entry MSB).
module rns_lut_sel #(
  parameter int unsigned W       = 5,
  parameter int unsigned ENTRIES = 2,
  parameter int unsigned IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic [0:W*ENTRIES-1] lut_i,
  input  logic [IDX_W-1:0]     k_i,
  output logic [W-1:0]         entry_o
);

  always_comb begin
    entry_o = lut_i[k_i*W +: W];
  end

endmodule

// File: rtl/bin_to_rns_32_31_21_5.sv
// Binary-to-RNS converter for moduli (32,31,21,5), one registered result per clock.
// Optional macro BIN2RNS_INPUT_REG_EN adds an input register on N (latency 2).
module bin_to_rns_32_31_21_5
  import rns_32_31_21_5_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_W-1:0]         N,
  input  logic [0:LUT_31_SIZE-1] LUT_mod_31,
  input  logic [0:LUT_21_SIZE-1] LUT_mod_21,
  input  logic [0:LUT_5_SIZE-1]  LUT_mod_5,
  output logic [RES_W-1:0]       x0,
  output logic [RES_W-1:0]       x1,
  output logic [RES_W-1:0]       x2,
  output logic [RES_W-1:0]       x3
);

  logic [N_W-1:0] n_src;

`ifdef BIN2RNS_INPUT_REG_EN
  logic [N_W-1:0] n_q;
  logic [N_W-1:0] n_d;

  always_comb begin
    n_d = N;
  end

  always_ff @(posedge clk) begin
    if (!reset) n_q <= '0;
    else        n_q <= n_d;
  end

  assign n_src = n_q;
`else
  assign n_src = N;
`endif

  // Modulo 31
  logic [4:0]  e0;
  logic [4:0]  e1;
  logic [9:0]  inner_b;
  logic [4:0]  b_fold;
  logic [10:0] a_sum;
  logic [11:0] tot31;

  rns_lut_sel #(.W(LUT_31_W), .ENTRIES(LUT_31_N)) u_lut31_e0 (
    .lut_i   (LUT_mod_31),
    .k_i     (1'b0),
    .entry_o (e0)
  );

  rns_lut_sel #(.W(LUT_31_W), .ENTRIES(LUT_31_N)) u_lut31_e1 (
    .lut_i   (LUT_mod_31),
    .k_i     (1'b1),
    .entry_o (e1)
  );

  always_comb begin
    inner_b = 10'(n_src[14:10]) + 10'(e1) * 10'(n_src[17:15]);
    b_fold  = fold_mod31(20'(inner_b));
    a_sum   = 11'(n_src[4:0]) + 11'(e1) * 11'(n_src[9:5]);
    tot31   = 12'(a_sum) + 12'(e0) * 12'(b_fold);
  end

  // Modulo 21: 2^6 == 1 (mod 21), and 42 is a multiple of 21
  logic [7:0] s21;
  logic [6:0] sp21;
  logic [5:0] t21;
  logic [4:0] r21;

  always_comb begin
    s21  = 8'(n_src[5:0]) + 8'(n_src[11:6]) + 8'(n_src[17:12]);
    sp21 = 7'(s21[5:0]) + 7'(s21[7:6]);
    t21  = (sp21 < 7'd46) ? sp21[5:0] : 6'(sp21 - 7'd42);
  end

  rns_lut_sel #(.W(LUT_21_W), .ENTRIES(LUT_21_N)) u_lut21 (
    .lut_i   (LUT_mod_21),
    .k_i     (t21),
    .entry_o (r21)
  );

  // Modulo 5: weights of bits 4..17 come from the LUT
  logic [LUT_5_W-1:0] w5 [LUT_5_N];
  logic [6:0]         sum5;

  for (genvar gi = 0; gi < LUT_5_N; gi++) begin : g_lut5
    rns_lut_sel #(.W(LUT_5_W), .ENTRIES(LUT_5_N)) u_lut5 (
      .lut_i   (LUT_mod_5),
      .k_i     (4'(gi)),
      .entry_o (w5[gi])
    );
  end

  always_comb begin
    sum5 = 7'(n_src[3:0]);
    for (int unsigned i = 0; i < LUT_5_N; i++) begin
      if (n_src[i+4]) sum5 = sum5 + 7'(w5[i]);
    end
  end

  // Output register
  rns_res_t res_d;
  rns_res_t res_q;

  always_comb begin
    res_d    = '0;
    res_d.x0 = n_src[4:0];
    res_d.x1 = fold_mod31(20'(tot31));
    res_d.x2 = r21;
    res_d.x3 = {2'b00, fold_mod5(sum5)};
  end

  always_ff @(posedge clk) begin
    if (!reset) res_q <= '0;
    else        res_q <= res_d;
  end

  assign x0 = res_q.x0;
  assign x1 = res_q.x1;
  assign x2 = res_q.x2;
  assign x3 = res_q.x3;

endmodule

// File: tb/tb_bin_to_rns_32_31_21_5.sv
// Scoreboard bench for bin_to_rns_32_31_21_5: expected residues queued at drive time, checked after the edge.
module tb_bin_to_rns_32_31_21_5;

  logic         clk;
  logic         reset;
  logic [17:0]  N;
  logic [0:9]   lut31;
  logic [0:229] lut21;
  logic [0:41]  lut5;
  logic [4:0]   x0, x1, x2, x3;

  int unsigned n_cmp;
  int unsigned n_err;
  int unsigned cur_n;

  typedef struct {
    int unsigned n;
    logic [4:0]  e0, e1, e2, e3;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_pipe;

  bin_to_rns_32_31_21_5 dut (
    .clk        (clk),
    .reset      (reset),
    .N          (N),
    .LUT_mod_31 (lut31),
    .LUT_mod_21 (lut21),
    .LUT_mod_5  (lut5),
    .x0         (x0),
    .x1         (x1),
    .x2         (x2),
    .x3         (x3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s N=%0d got=%0d expected=%0d", tag, cur_n, got, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cur_n = e.n;
      chk("x0", x0, e.e0);
      chk("x1", x1, e.e1);
      chk("x2", x2, e.e2);
      chk("x3", x3, e.e3);
    end
  endtask

  // Drives one operand per clock and queues what the next edge must produce.
  task automatic step(input int unsigned nv, input bit rv);
    exp_t        e;
    int unsigned eff;
    @(negedge clk);
    check_out();
    N     = 18'(nv);
    reset = rv;
`ifdef BIN2RNS_INPUT_REG_EN
    eff    = n_pipe;
    n_pipe = rv ? nv : 0;
`else
    eff = nv;
`endif
    e.n = eff;
    if (rv) begin
      e.e0 = 5'(eff % 32);
      e.e1 = 5'(eff % 31);
      e.e2 = 5'(eff % 21);
      e.e3 = 5'(eff % 5);
    end else begin
      e.e0 = '0; e.e1 = '0; e.e2 = '0; e.e3 = '0;
    end
    sb.push_back(e);
  endtask

  task automatic check_fixed(input string tag, input logic [4:0] a, b, c, d);
    exp_t e;
    @(negedge clk);
    e = sb.pop_front();
    cur_n = e.n;
    chk({tag, ".x0"}, x0, a);
    chk({tag, ".x1"}, x1, b);
    chk({tag, ".x2"}, x2, c);
    chk({tag, ".x3"}, x3, d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1);
  end

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    cur_n  = 0;
    n_pipe = 0;
    reset  = 1'b0;
    N      = 18'd1000;
    for (int i = 0; i < 14; i++) lut5[i*3 +: 3] = 3'((1 << (i + 4)) % 5);
    lut31[0 +: 5] = 5'(1024 % 31);
    lut31[5 +: 5] = 5'(32 % 31);
    for (int i = 0; i < 46; i++) lut21[i*5 +: 5] = 5'(i % 21);

    // Reset held with a nonzero operand
    step(1000, 1'b0);
    step(1000, 1'b0);
    step(0, 1'b1);
    step(1000, 1'b1);
    step(104159, 1'b1);
    step(262143, 1'b1);
    // Mid-stream reset discards the in-flight result
    step(1000, 1'b0);
    step(1000, 1'b1);
    step(1000, 1'b1);
    check_out();

`ifndef BIN2RNS_INPUT_REG_EN
    // Fixed-vector checks on the 1-cycle path with literal expectations
    sb.delete();
    step(1000, 1'b1);
    check_fixed("n1000", 5'd8, 5'd8, 5'd13, 5'd0);
    step(104159, 1'b1);
    check_fixed("n104159", 5'd31, 5'd30, 5'd20, 5'd4);
    step(262143, 1'b1);
    check_fixed("n262143", 5'd31, 5'd7, 5'd0, 5'd3);
    step(1000, 1'b0);
    check_fixed("rst_lo", 5'd0, 5'd0, 5'd0, 5'd0);
    step(1000, 1'b1);
    check_fixed("rst_rel", 5'd8, 5'd8, 5'd13, 5'd0);
    sb.delete();
`endif

    for (int unsigned v = 0; v < 65536; v++) step(v, 1'b1);
    step(262143, 1'b1);
    step(0, 1'b1);
    @(negedge clk);
    check_out();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
